// File: rtl/logic_ops_pkg.sv
// Shared definitions for the bitwise logic unit: opcode encoding and default width.
package logic_ops_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise logic unit with result flags; shared with the single-cycle ALU path.
module logic_op_core
    import logic_ops_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [2:0]     op,
    input  logic [WIDTH:1] A,
    input  logic [WIDTH:1] B,
    output logic [WIDTH:1] result,
    output logic           zero,
    output logic           ones,
    output logic           parity
);

    // Select the bitwise operation; B is unused for NOT and PASS.
    always_comb begin
        result = '0;
        unique case (op_e'(op))
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_NOR:  result = ~(A | B);
            OP_NAND: result = ~(A & B);
            OP_XOR:  result = A ^ B;
            OP_XNOR: result = ~(A ^ B);
            OP_NOT:  result = ~A;
            OP_PASS: result = A;
            default: result = '0;
        endcase
    end

    // Flags describe the selected result only.
    always_comb begin
        zero   = ~|result;
        ones   = &result;
        parity = ^result;
    end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready pipeline around the bitwise logic unit with a completion counter.
module logic_op_pipe
    import logic_ops_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH:1]   A,
    input  logic [WIDTH:1]   B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   out,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] ops_done
);

    logic           s1_valid;
    logic [2:0]     s1_op;
    logic [WIDTH:1] s1_a;
    logic [WIDTH:1] s1_b;

    logic           s2_free;
    logic           s1_adv;
    logic           accept;

    logic [WIDTH:1] core_res;
    logic           core_zero;
    logic           core_ones;
    logic           core_parity;

    // Handshake control: S2 frees when empty or draining, S1 frees when empty or advancing.
    always_comb begin
        s2_free  = !out_valid || out_ready;
        s1_adv   = s1_valid && s2_free;
        in_ready = !s1_valid || s2_free;
        accept   = in_valid && in_ready;
    end

    // S1 operand latch; a new accept and an advance in the same cycle keep s1_valid set.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_a     <= A;
            s1_b     <= B;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .A      (s1_a),
        .B      (s1_b),
        .result (core_res),
        .zero   (core_zero),
        .ones   (core_ones),
        .parity (core_parity)
    );

    // S2 result register; holds result and flags while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b1;
            ones      <= 1'b0;
            parity    <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out       <= core_res;
            zero      <= core_zero;
            ones      <= core_ones;
            parity    <= core_parity;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_done <= '0;
        end else if (out_valid && out_ready) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe.
module tb_logic_op_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [16:1] A;
    logic [16:1] B;
    logic        out_valid;
    logic        out_ready;
    logic [16:1] out;
    logic        zero;
    logic        ones;
    logic        parity;
    logic [7:0]  ops_done;

    int errors = 0;
    int checks = 0;

    logic [16:1] exp_res [4];
    logic        exp_par [4];

    logic_op_pipe #(.WIDTH(16), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input logic [16:1] r, input logic z,
                           input logic o, input logic p);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(1));
        chk({tag, ".out"},       32'(out),       32'(r));
        chk({tag, ".zero"},      32'(zero),      32'(z));
        chk({tag, ".ones"},      32'(ones),      32'(o));
        chk({tag, ".parity"},    32'(parity),    32'(p));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [16:1] a,
                         input logic [16:1] b);
        in_valid = v;
        op       = o;
        A        = a;
        B        = b;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        step();
        step();
        // Reset state
        chk("rst.out_valid", 32'(out_valid), 32'(0));
        chk("rst.out",       32'(out),       32'(0));
        chk("rst.zero",      32'(zero),      32'(1));
        chk("rst.ones",      32'(ones),      32'(0));
        chk("rst.parity",    32'(parity),    32'(0));
        chk("rst.ops_done",  32'(ops_done),  32'(0));
        chk("rst.in_ready",  32'(in_ready),  32'(1));
        reset = 1'b0;
        step();

        // NOR 00FF/0F0F -> F000
        drive(1'b1, 3'd2, 16'h00FF, 16'h0F0F);
        step();
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        chk("nor.early", 32'(out_valid), 32'(0));
        step();
        chk_out("nor", 16'hF000, 1'b0, 1'b0, 1'b0);
        chk("nor.cnt_before", 32'(ops_done), 32'(0));
        step();
        chk("nor.drained", 32'(out_valid), 32'(0));
        chk("nor.cnt", 32'(ops_done), 32'(1));

        // AND FFFF/FFFF then XOR 1234/1234 back-to-back
        drive(1'b1, 3'd0, 16'hFFFF, 16'hFFFF);
        step();
        drive(1'b1, 3'd4, 16'h1234, 16'h1234);
        step();
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        chk_out("and", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        step();
        chk_out("xor", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        chk("andxor.drained", 32'(out_valid), 32'(0));
        chk("andxor.cnt", 32'(ops_done), 32'(3));

        // Stream of 4: NAND, NOT, XNOR, PASS with B don't-care
        exp_res[0] = 16'hFFF0; exp_par[0] = 1'b0;
        exp_res[1] = 16'hFFFE; exp_par[1] = 1'b1;
        exp_res[2] = 16'hF00F; exp_par[2] = 1'b0;
        exp_res[3] = 16'hA5A5; exp_par[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 3'd3, 16'h00FF, 16'h0F0F);
                1: drive(1'b1, 3'd6, 16'h0001, 16'hBEEF);
                2: drive(1'b1, 3'd5, 16'hF0F0, 16'hFF00);
                3: drive(1'b1, 3'd7, 16'hA5A5, 16'h1234);
                default: drive(1'b0, 3'd0, 16'h0000, 16'h0000);
            endcase
            if (i < 4) chk($sformatf("stream.in_ready%0d", i), 32'(in_ready), 32'(1));
            step();
            if (i >= 1) chk_out($sformatf("stream%0d", i - 1), exp_res[i - 1], 1'b0, 1'b0,
                                exp_par[i - 1]);
        end
        step();
        chk("stream.drained", 32'(out_valid), 32'(0));
        chk("stream.cnt", 32'(ops_done), 32'(7));

        // Backpressure: OR, AND, NOR issued with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h1200, 16'h0034);
        chk("bp.in_ready0", 32'(in_ready), 32'(1));
        step();
        drive(1'b1, 3'd0, 16'hF0F0, 16'h3C3C);
        chk("bp.in_ready1", 32'(in_ready), 32'(1));
        step();
        drive(1'b1, 3'd2, 16'h0000, 16'h0000);
        chk("bp.in_ready2", 32'(in_ready), 32'(0));
        chk_out("bp.hold0", 16'h1234, 1'b0, 1'b0, 1'b1);
        step();
        chk("bp.in_ready3", 32'(in_ready), 32'(0));
        chk_out("bp.hold1", 16'h1234, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("bp.hold2", 16'h1234, 1'b0, 1'b0, 1'b1);
        chk("bp.cnt_stall", 32'(ops_done), 32'(7));
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_rel", 32'(in_ready), 32'(1));
        step();
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        chk_out("bp.drain1", 16'h3030, 1'b0, 1'b0, 1'b0);
        chk("bp.cnt1", 32'(ops_done), 32'(8));
        step();
        chk_out("bp.drain2", 16'hFFFF, 1'b0, 1'b1, 1'b0);
        chk("bp.cnt2", 32'(ops_done), 32'(9));
        step();
        chk("bp.drained", 32'(out_valid), 32'(0));
        chk("bp.cnt3", 32'(ops_done), 32'(10));

        // Counter wrap: 246 more handshakes bring the total to 256
        for (int s = 1; s <= 248; s++) begin
            if (s <= 246) drive(1'b1, 3'd7, 16'(s), 16'hFFFF);
            else          drive(1'b0, 3'd0, 16'h0000, 16'h0000);
            step();
            if (s == 247) begin
                chk("wrap.cnt255", 32'(ops_done), 32'(255));
                chk("wrap.last", 32'(out), 32'(246));
            end
        end
        chk("wrap.cnt0", 32'(ops_done), 32'(0));
        chk("wrap.drained", 32'(out_valid), 32'(0));

        // Reset with S1 and S2 both full
        drive(1'b1, 3'd4, 16'h00FF, 16'h0F0F);
        step();
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        step();
        step();
        chk("mid.cnt1", 32'(ops_done), 32'(1));
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h1111, 16'h2222);
        step();
        drive(1'b1, 3'd1, 16'h4444, 16'h8888);
        step();
        drive(1'b0, 3'd0, 16'h0000, 16'h0000);
        chk("mid.full_in_ready", 32'(in_ready), 32'(0));
        chk_out("mid.full", 16'h3333, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk("mid.out_valid", 32'(out_valid), 32'(0));
        chk("mid.cnt", 32'(ops_done), 32'(0));
        chk("mid.in_ready", 32'(in_ready), 32'(1));
        chk("mid.out", 32'(out), 32'(0));
        chk("mid.zero", 32'(zero), 32'(1));
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mid.nostale%0d", k), 32'(out_valid), 32'(0));
        end
        chk("mid.cnt_after", 32'(ops_done), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
